// File: rtl/periph_target_adapter.sv
// rtl/periph_target_adapter.sv - peripheral request/grant/response to register-bus adapter
//
// Terminates one cluster peripheral demux port. Each grant turns into one
// register-bus access, and exactly one response comes back for it. Only one
// access is outstanding at a time. A watchdog forces an error response if the
// backend never acknowledges.
//
// Ports:
//   clk, rst_ni                          clock, asynchronous active-low reset
//   data_req_i/add/wen/wdata/be          core request (wen: 1 = read, 0 = write)
//   data_gnt_o                           grant, combinational from req and state
//   data_r_valid_o/rdata/opc             one-cycle response with data and error flag
//   reg_req_o/add/wen/wdata/be           register-bus request, held stable while busy
//   reg_ack_i/rdata/err                  backend completion with read data and error
module periph_target_adapter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int BE_WIDTH       = DATA_WIDTH / 8,
    parameter int REG_ADDR_WIDTH = 10,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      rst_ni,
    input  logic                      data_req_i,
    input  logic [ADDR_WIDTH-1:0]     data_add_i,
    input  logic                      data_wen_i,
    input  logic [DATA_WIDTH-1:0]     data_wdata_i,
    input  logic [BE_WIDTH-1:0]       data_be_i,
    output logic                      data_gnt_o,
    output logic                      data_r_valid_o,
    output logic [DATA_WIDTH-1:0]     data_r_rdata_o,
    output logic                      data_r_opc_o,
    output logic                      reg_req_o,
    output logic [REG_ADDR_WIDTH-1:0] reg_add_o,
    output logic                      reg_wen_o,
    output logic [DATA_WIDTH-1:0]     reg_wdata_o,
    output logic [BE_WIDTH-1:0]       reg_be_o,
    input  logic                      reg_ack_i,
    input  logic [DATA_WIDTH-1:0]     reg_rdata_i,
    input  logic                      reg_err_i
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
    localparam int TO_LAST_INT = TO_EN ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CW-1:0] TO_LAST = TO_LAST_INT[CW-1:0];

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  opc_q;
    logic                  capture;
    logic                  timeout_hit;

    // Only the low address bits matter to the register bus.
    logic unused_add;
    assign unused_add = ^data_add_i[ADDR_WIDTH-1:REG_ADDR_WIDTH];

    // A new request is accepted whenever no access is in flight. This includes
    // the RESP cycle, so back-to-back accesses take one transaction per two cycles.
    assign capture     = (state != BUSY) && data_req_i;
    assign timeout_hit = TO_EN && (cnt == TO_LAST);

    // State register
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = data_req_i ? BUSY : IDLE;
            // When the ack and the timeout land in the same cycle, the ack wins.
            // Both cases lead to RESP, and the datapath picks the payload.
            BUSY:    state_next = (reg_ack_i || timeout_hit) ? RESP : BUSY;
            RESP:    state_next = data_req_i ? BUSY : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        data_gnt_o     = 1'b0;
        reg_req_o      = 1'b0;
        data_r_valid_o = 1'b0;
        data_r_rdata_o = '0;
        data_r_opc_o   = 1'b0;
        case (state)
            IDLE: data_gnt_o = data_req_i;
            BUSY: reg_req_o  = 1'b1;
            RESP: begin
                data_gnt_o     = data_req_i;
                data_r_valid_o = 1'b1;
                data_r_rdata_o = rdata_q;
                data_r_opc_o   = opc_q;
            end
            default: ;
        endcase
    end

    // Request capture, watchdog counter and response latch
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            reg_add_o   <= '0;
            reg_wen_o   <= 1'b0;
            reg_wdata_o <= '0;
            reg_be_o    <= '0;
            cnt         <= '0;
            rdata_q     <= '0;
            opc_q       <= 1'b0;
        end else if (capture) begin
            reg_add_o   <= data_add_i[REG_ADDR_WIDTH-1:0];
            reg_wen_o   <= data_wen_i;
            reg_wdata_o <= data_wdata_i;
            reg_be_o    <= data_be_i;
            cnt         <= '0;
        end else if (state == BUSY) begin
            if (reg_ack_i) begin
                // Writes always return zero data.
                rdata_q <= reg_wen_o ? reg_rdata_i : '0;
                opc_q   <= reg_err_i;
            end else begin
                // The counter saturates instead of wrapping.
                if (cnt != '1) begin
                    cnt <= cnt + CW'(1);
                end
                if (timeout_hit) begin
                    rdata_q <= '0;
                    opc_q   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_periph_target_adapter.sv
// tb/tb_periph_target_adapter.sv - self-checking bench for periph_target_adapter
module tb_periph_target_adapter;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        data_req = 1'b0;
    logic [31:0] data_add = '0;
    logic        data_wen = 1'b0;
    logic [31:0] data_wdata = '0;
    logic [3:0]  data_be = '0;
    logic        data_gnt;
    logic        r_valid;
    logic [31:0] r_rdata;
    logic        r_opc;
    logic        reg_req;
    logic [9:0]  reg_add;
    logic        reg_wen;
    logic [31:0] reg_wdata;
    logic [3:0]  reg_be;
    logic        reg_ack = 1'b0;
    logic [31:0] reg_rdata = '0;
    logic        reg_err = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    periph_target_adapter #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .BE_WIDTH(4),
        .REG_ADDR_WIDTH(10), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_ni(rst_n),
        .data_req_i(data_req), .data_add_i(data_add), .data_wen_i(data_wen),
        .data_wdata_i(data_wdata), .data_be_i(data_be), .data_gnt_o(data_gnt),
        .data_r_valid_o(r_valid), .data_r_rdata_o(r_rdata), .data_r_opc_o(r_opc),
        .reg_req_o(reg_req), .reg_add_o(reg_add), .reg_wen_o(reg_wen),
        .reg_wdata_o(reg_wdata), .reg_be_o(reg_be),
        .reg_ack_i(reg_ack), .reg_rdata_i(reg_rdata), .reg_err_i(reg_err)
    );

    function automatic logic [31:0] bk_data(input logic [9:0] a);
        return {a, 6'h2a, ~a, 6'h15};
    endfunction

    // One transaction starting from IDLE at posedge+1. ack_dly is the BUSY
    // cycle index (0 = first) on which the backend acks; it may fall past the
    // timeout, and a negative value means the backend never acks.
    task automatic run_txn(input string nm, input logic [31:0] a, input logic w,
                           input logic [31:0] wd, input logic [3:0] be,
                           input int ack_dly, input logic [31:0] rd, input logic er);
        int lat;
        logic [31:0] exp_rd;
        logic exp_opc;
        if (ack_dly >= 0 && ack_dly < TO) begin
            lat = ack_dly + 2; exp_rd = w ? rd : 32'h0; exp_opc = er;
        end else begin
            lat = TO + 1; exp_rd = 32'h0; exp_opc = 1'b1;
        end
        data_req = 1'b1; data_add = a; data_wen = w; data_wdata = wd; data_be = be;
        @(negedge clk);
        checks++;
        if (data_gnt !== 1'b1) begin
            failures++; $display("FAIL %s gnt: got %b want 1", nm, data_gnt);
        end
        @(posedge clk); #1;
        data_req = 1'b0; data_add = $urandom; data_wen = $urandom; data_wdata = $urandom; data_be = $urandom;
        for (int k = 1; k <= lat + 1; k++) begin
            reg_ack   = (k - 1 == ack_dly);
            reg_rdata = reg_ack ? rd : $urandom;
            reg_err   = reg_ack ? er : 1'($urandom);
            @(negedge clk);
            if (k < lat) begin
                checks++;
                if (reg_req !== 1'b1 || r_valid !== 1'b0 || reg_add !== a[9:0] || reg_wen !== w ||
                    reg_wdata !== wd || reg_be !== be) begin
                    failures++;
                    $display("FAIL %s busy@%0d: req=%b vld=%b add=%h wen=%b wd=%h be=%h want req=1 vld=0 add=%h wen=%b wd=%h be=%h",
                             nm, k, reg_req, r_valid, reg_add, reg_wen, reg_wdata, reg_be, a[9:0], w, wd, be);
                end
            end else if (k == lat) begin
                checks++;
                if (r_valid !== 1'b1 || r_rdata !== exp_rd || r_opc !== exp_opc || reg_req !== 1'b0) begin
                    failures++;
                    $display("FAIL %s resp@%0d: vld=%b rdata=%h opc=%b req=%b want vld=1 rdata=%h opc=%b req=0",
                             nm, k, r_valid, r_rdata, r_opc, reg_req, exp_rd, exp_opc);
                end
            end else begin
                checks++;
                if (r_valid !== 1'b0 || r_rdata !== 32'h0 || r_opc !== 1'b0 || reg_req !== 1'b0) begin
                    failures++;
                    $display("FAIL %s after: vld=%b rdata=%h opc=%b req=%b want all 0",
                             nm, r_valid, r_rdata, r_opc, reg_req);
                end
            end
            @(posedge clk); #1;
        end
        reg_ack = 1'b0; reg_err = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (data_gnt !== 0 || r_valid !== 0 || r_rdata !== 0 || r_opc !== 0 || reg_req !== 0 ||
            reg_add !== 0 || reg_wen !== 0 || reg_wdata !== 0 || reg_be !== 0) begin
            failures++;
            $display("FAIL reset: gnt=%b vld=%b rd=%h opc=%b req=%b add=%h wen=%b wd=%h be=%h want all 0",
                     data_gnt, r_valid, r_rdata, r_opc, reg_req, reg_add, reg_wen, reg_wdata, reg_be);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_read_fast();
        run_txn("read_fast", 32'h0000_0123, 1'b1, 32'h0, 4'hF, 0, 32'hCAFE_F00D, 1'b0);
    endtask

    task automatic test_write_delayed();
        run_txn("write_dly", 32'h1020_4404, 1'b0, 32'h0000_1234, 4'hF, 3, 32'hDEAD_BEEF, 1'b0);
    endtask

    task automatic test_timeout();
        // The ack arrives in the RESP cycle and is ignored.
        run_txn("timeout_resp_ack", 32'h0000_0010, 1'b1, 32'h0, 4'hF, TO, 32'h5555_AAAA, 1'b0);
        // The ack arrives in the following IDLE cycle and is ignored.
        run_txn("timeout_idle_ack", 32'h0000_0014, 1'b1, 32'h0, 4'hF, TO + 1, 32'h5555_AAAA, 1'b0);
        run_txn("timeout_none", 32'h0000_0018, 1'b0, 32'h77, 4'h3, -1, 32'h0, 1'b0);
    endtask

    task automatic test_ack_last_cycle();
        run_txn("ack_last", 32'h0000_0200, 1'b1, 32'h0, 4'hF, TO - 1, 32'h1357_9BDF, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [31:0] expq[$];
        logic        expo[$];
        int n_gnt = 0, n_resp = 0, last_resp = -1, cyc = 0;
        logic granted;
        data_req = 1'b1; data_add = $urandom; data_wen = $urandom; data_wdata = $urandom; data_be = $urandom;
        while (cyc < 60 && n_resp < 8) begin
            // Backend acks immediately and returns data derived from the address.
            reg_ack = reg_req; reg_rdata = bk_data(reg_add); reg_err = reg_add[0];
            @(negedge clk);
            granted = data_gnt;
            if (r_valid) begin
                checks++;
                if (expq.size() == 0) begin
                    failures++; $display("FAIL b2b extra response rdata=%h", r_rdata);
                end else begin
                    if (r_rdata !== expq[0] || r_opc !== expo[0]) begin
                        failures++;
                        $display("FAIL b2b resp%0d: rdata=%h opc=%b want rdata=%h opc=%b",
                                 n_resp, r_rdata, r_opc, expq[0], expo[0]);
                    end
                    void'(expq.pop_front()); void'(expo.pop_front());
                end
                if (last_resp >= 0) begin
                    checks++;
                    if (cyc - last_resp != 2) begin
                        failures++; $display("FAIL b2b spacing: got %0d want 2", cyc - last_resp);
                    end
                end
                last_resp = cyc;
                n_resp++;
            end
            if (granted) begin
                expq.push_back(data_wen ? bk_data(data_add[9:0]) : 32'h0);
                expo.push_back(data_add[0]);
                n_gnt++;
            end
            @(posedge clk); #1;
            cyc++;
            if (granted) begin
                data_add = $urandom; data_wen = $urandom; data_wdata = $urandom; data_be = $urandom;
                if (n_gnt == 8) data_req = 1'b0;
            end
        end
        reg_ack = 1'b0; reg_err = 1'b0;
        checks++;
        if (n_gnt !== 8 || n_resp !== 8) begin
            failures++; $display("FAIL b2b count: gnt=%0d resp=%0d want 8/8", n_gnt, n_resp);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        data_req = 1'b1; data_add = 32'h0000_0300; data_wen = 1'b1;
        @(posedge clk); #1;
        data_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (reg_req !== 1'b0 || r_valid !== 1'b0) begin
            failures++; $display("FAIL rst_mid: req=%b vld=%b want 0/0", reg_req, r_valid);
        end
        for (int i = 0; i < 3; i++) begin
            reg_ack = (i == 0); reg_rdata = 32'hFFFF_0000;
            @(negedge clk);
            checks++;
            if (r_valid !== 1'b0 || reg_req !== 1'b0) begin
                failures++; $display("FAIL rst_mid hold%0d: vld=%b req=%b want 0/0", i, r_valid, reg_req);
            end
        end
        reg_ack = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_txn("after_rst", 32'h0000_0304, 1'b1, 32'h0, 4'hF, 1, 32'h0BAD_F00D, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            int d;
            d = int'($urandom_range(0, 21)) - 1;
            run_txn("random", $urandom, 1'($urandom), $urandom, 4'($urandom), d, $urandom, 1'($urandom));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_read_fast();
        test_write_delayed();
        test_timeout();
        test_ack_last_cycle();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
